// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto NUM_VOICES channels and
// programs the chosen channel through a three-phase strobed register bus.
module voice_allocator #(
  parameter int          NUM_VOICES  = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter logic [15:0] ADDR_STRIDE = 16'h0010
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  NoteValid,
  output logic                  NoteReady,
  input  logic                  NoteOn,
  input  logic [6:0]            NoteNum,
  input  logic [6:0]            Velocity,
  output logic [15:0]           BusAddress,
  output logic [7:0]            BusDataOut,
  output logic                  BusDataOe,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] ActiveMask,
  output logic                  Busy
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    WR_HOLD   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    on_q, on_d;
  logic [6:0]              note_q, note_d;
  logic [6:0]              vel_q, vel_d;
  logic [VW-1:0]           voice_q, voice_d;
  logic [1:0]              off_q, off_d;
  logic [NUM_VOICES-1:0]   mask_q, mask_d;
  logic [7:0]              age_q [NUM_VOICES];
  logic [7:0]              age_d [NUM_VOICES];
  logic [6:0]              nm_q [NUM_VOICES];
  logic [6:0]              nm_d [NUM_VOICES];
  logic [15:0]             addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    oe_q, oe_d;
  logic                    clk_q, clk_d;
  logic                    ready_q, ready_d;

  logic                    hit_s, free_s, old_s;
  logic [VW-1:0]           hit_idx_s, free_idx_s, old_idx_s, pick_s;
  logic [7:0]              old_age_s;
  logic                    in_wr_s;

  function automatic logic [15:0] voice_addr(input logic [VW-1:0] v, input logic [1:0] off);
    return BASE_ADDR + (16'(v) * ADDR_STRIDE) + {14'd0, off};
  endfunction

  // Register offset selects the payload: pitch, velocity, then gate bit.
  function automatic logic [7:0] wr_data(input logic [1:0] off, input logic on,
                                         input logic [6:0] note, input logic [6:0] vel);
    case (off)
      2'd0:    return {1'b0, note};
      2'd1:    return {1'b0, vel};
      default: return {7'd0, on};
    endcase
  endfunction

  // Candidate voices: same-note match, first free slot, and oldest active slot.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    old_s      = 1'b0;
    old_idx_s  = '0;
    old_age_s  = 8'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (mask_q[i] && (nm_q[i] == note_q) && !hit_s) begin
        hit_s     = 1'b1;
        hit_idx_s = VW'(i);
      end else if (!mask_q[i] && !free_s) begin
        free_s     = 1'b1;
        free_idx_s = VW'(i);
      end else begin
        hit_s = hit_s;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (mask_q[i] && (!old_s || (age_q[i] > old_age_s))) begin
        old_s     = 1'b1;
        old_idx_s = VW'(i);
        old_age_s = age_q[i];
      end else begin
        old_s = old_s;
      end
    end
    pick_s = hit_s ? hit_idx_s : (free_s ? free_idx_s : old_idx_s);
  end

  // Next-state, bookkeeping and registered-output computation.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    note_d  = note_q;
    vel_d   = vel_q;
    voice_d = voice_q;
    off_d   = off_q;
    mask_d  = mask_q;
    age_d   = age_q;
    nm_d    = nm_q;
    case (state_q)
      IDLE: begin
        if (NoteValid) begin
          on_d    = NoteOn;
          note_d  = NoteNum;
          vel_d   = Velocity;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (on_q) begin
          voice_d = pick_s;
          off_d   = 2'd0;
          state_d = WR_SETUP;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (VW'(i) == pick_s) begin
              age_d[i] = 8'd0;
              nm_d[i]  = note_q;
            end else if (mask_q[i] && (age_q[i] != 8'hFF)) begin
              age_d[i] = age_q[i] + 8'd1;
            end else begin
              age_d[i] = age_q[i];
            end
          end
        end else if (hit_s) begin
          voice_d = hit_idx_s;
          off_d   = 2'd2;
          state_d = WR_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WR_SETUP: state_d = WR_STROBE;
      WR_STROBE: begin
        state_d = WR_HOLD;
        if (off_q == 2'd2) begin
          mask_d[voice_q] = on_q;
        end else begin
          mask_d = mask_q;
        end
      end
      WR_HOLD: begin
        if (off_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          off_d   = off_q + 2'd1;
          state_d = WR_SETUP;
        end
      end
      default: state_d = IDLE;
    endcase

    in_wr_s = (state_d == WR_SETUP) || (state_d == WR_STROBE) || (state_d == WR_HOLD);
    addr_d  = in_wr_s ? voice_addr(voice_d, off_d) : 16'h0000;
    data_d  = in_wr_s ? wr_data(off_d, on_d, note_d, vel_d) : 8'h00;
    oe_d    = in_wr_s;
    clk_d   = (state_d == WR_STROBE);
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset abandons any write in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      on_q    <= 1'b0;
      note_q  <= 7'd0;
      vel_q   <= 7'd0;
      voice_q <= '0;
      off_q   <= 2'd0;
      mask_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_q[i] <= 8'd0;
        nm_q[i]  <= 7'd0;
      end
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      oe_q    <= 1'b0;
      clk_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      voice_q <= voice_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      age_q   <= age_d;
      nm_q    <= nm_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      clk_q   <= clk_d;
      ready_q <= ready_d;
    end
  end

  assign NoteReady    = ready_q;
  assign Busy         = !ready_q;
  assign BusAddress   = addr_q;
  assign BusDataOut   = data_q;
  assign BusDataOe    = oe_q;
  assign BusReadWrite = oe_q;
  assign BusClock     = clk_q;
  assign ActiveMask   = mask_q;

endmodule
